// File: rtl/tmds_8b10b_encoder_pkg.sv
// Constants shared by the TMDS encoder and decoder: symbol modes, control,
// TERC4 and guard-band code words.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_TERC4  = 3'd2,
        MODE_VGUARD = 3'd3,
        MODE_DGUARD = 3'd4
    } mode_t;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    localparam logic [9:0] GUARD_VIDEO_02 = 10'h2CC;
    localparam logic [9:0] GUARD_VIDEO_1  = 10'h133;
    localparam logic [9:0] GUARD_DATA     = 10'h133;

    // Entry [n] is the TERC4 word for nibble n.
    localparam logic [15:0][9:0] TERC4_TABLE = {
        10'h2C3, 10'h163, 10'h271, 10'h28E, 10'h2C6, 10'h19C, 10'h139, 10'h2CC,
        10'h13C, 10'h18E, 10'h11E, 10'h171, 10'h2E2, 10'h2E4, 10'h263, 10'h29C
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_word(input logic [1:0] sync);
        case (sync)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    function automatic logic [9:0] terc4_word(input logic [3:0] nibble);
        return TERC4_TABLE[nibble];
    endfunction

endpackage

// File: rtl/tmds_8b10b_encoder_if.sv
// Symbol input / TMDS word output bundle of one encoder channel.
interface tmds_8b10b_encoder_if;
    logic [2:0] mode;
    logic [7:0] data;
    logic [1:0] sync;
    logic [3:0] ctrl;
    logic [9:0] out;
    logic [4:0] disparity;

    modport master (output mode, data, sync, ctrl, input out, disparity);
    modport slave  (input mode, data, sync, ctrl, output out, disparity);
endinterface

// File: rtl/tmds_8b10b_encoder_qm.sv
// Stage 1: transition-minimising xor/xnor chain, registered together with
// the ones/zeros counts of the resulting qm[7:0].
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    output logic [8:0] qm,
    output logic [3:0] n1,
    output logic [3:0] n0
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [3:0] n1_next;

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        qm_next    = 9'd0;
        qm_next[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data[i]) : (qm_next[i-1] ^ data[i]);
        end
        qm_next[8] = ~use_xnor;
        n1_next    = popcount8(qm_next[7:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qm <= 9'd0;
            n1 <= 4'd0;
            n0 <= 4'd0;
        end else begin
            qm <= qm_next;
            n1 <= n1_next;
            n0 <= 4'd8 - n1_next;
        end
    end

endmodule

// File: rtl/tmds_8b10b_encoder.sv
// One TMDS channel encoder: two-cycle pipeline, stage 1 in tmds_qm_stage,
// stage 2 selects the output word and tracks running disparity.
module tmds_8b10b_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic clk,
    input  logic reset,
    tmds_8b10b_encoder_if.slave bus
);

    logic [8:0] qm;
    logic [3:0] n1;
    logic [3:0] n0;

    tmds_qm_stage u_qm (
        .clk   (clk),
        .reset (reset),
        .data  (bus.data),
        .qm    (qm),
        .n1    (n1),
        .n0    (n0)
    );

    // Side-band fields travel alongside qm so both stages stay aligned.
    logic [2:0] mode_reg;
    logic [1:0] sync_reg;
    logic [3:0] ctrl_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg <= MODE_CTRL;
            sync_reg <= 2'b00;
            ctrl_reg <= 4'd0;
        end else begin
            mode_reg <= bus.mode;
            sync_reg <= bus.sync;
            ctrl_reg <= bus.ctrl;
        end
    end

    logic signed [4:0] cnt_reg, cnt_next;
    logic        [9:0] out_reg, out_next;
    logic signed [5:0] cnt_ext, diff, cnt_sum;
    logic              cnt_pos, cnt_neg;
    logic              cnt_unused;

    always_comb begin
        cnt_ext  = {cnt_reg[4], cnt_reg};
        diff     = $signed({2'b00, n1}) - $signed({2'b00, n0});
        cnt_pos  = !cnt_reg[4] && (cnt_reg != 5'sd0);
        cnt_neg  = cnt_reg[4];
        cnt_sum  = 6'sd0;
        out_next = CTRL_00;
        case (mode_reg)
            MODE_VIDEO: begin
                if ((cnt_reg == 5'sd0) || (n1 == n0)) begin
                    out_next = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    cnt_sum  = qm[8] ? (cnt_ext + diff) : (cnt_ext - diff);
                end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
                    out_next = {1'b1, qm[8], ~qm[7:0]};
                    cnt_sum  = cnt_ext - diff + (qm[8] ? 6'sd2 : 6'sd0);
                end else begin
                    out_next = {1'b0, qm[8], qm[7:0]};
                    cnt_sum  = cnt_ext + diff - (qm[8] ? 6'sd0 : 6'sd2);
                end
            end
            MODE_TERC4:  out_next = terc4_word(ctrl_reg);
            MODE_VGUARD: out_next = (CHANNEL == 1) ? GUARD_VIDEO_1 : GUARD_VIDEO_02;
            MODE_DGUARD: out_next = (CHANNEL == 0) ? terc4_word(ctrl_reg) : GUARD_DATA;
            default:     out_next = ctrl_word(sync_reg);
        endcase
        // Disparity is bounded to +/-10, so the sixth bit never carries information.
        cnt_next   = cnt_sum[4:0];
        cnt_unused = cnt_sum[5];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg <= CTRL_00;
            cnt_reg <= 5'sd0;
        end else begin
            out_reg <= out_next;
            cnt_reg <= cnt_next;
        end
    end

    assign bus.out       = out_reg;
    assign bus.disparity = cnt_reg;

endmodule

// File: doc/tmds_8b10b_encoder.md
Name: tmds_8b10b_encoder

Overview:
- Single-channel TMDS transmitter encoder. Converts one pixel-clock symbol (video byte, sync pair, TERC4 nibble or guard band) into a 10-bit TMDS word.
- Maintains DC balance with a running-disparity counter.
- Three instances (CHANNEL 0/1/2) feed a downstream 10:1 serializer, with bit 0 transmitted first.
- Words it emits are decoded bit-exactly by tmds_8b10b_decoder: out[9] is the invert flag and out[8] is the xor flag.

Parameters:
- CHANNEL, 0, TMDS channel index (0 = blue/sync, 1 = green, 2 = red). Selects the guard-band patterns.

Ports:
- clk  in  1  pixel clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  3  symbol type: 0 control, 1 video, 2 TERC4, 3 video guard, 4 data guard, 5-7 treated as control.
- data  in  8  video byte, used when mode = 1.
- sync  in  2  {vsync, hsync} control bits, used when mode = 0.
- ctrl  in  4  TERC4 nibble, used when mode = 2 (and mode = 4 on CHANNEL 0).
- out  out  10  encoded TMDS word.
- disparity  out  5  signed running disparity after the word currently on out (for verification).

Behaviour:
- Reset (async, any time, including mid-line):
  - out = 10'h354 (CTRL_00) and disparity = 0 immediately.
  - All pipeline registers clear to mode = control, sync = 00.
  - The first post-reset output reflects inputs sampled at least 2 edges after deassertion.
- Latency: exactly 2 clk cycles from input sample to out, for every mode.
  - No stalls and no handshake: one word per clock, always.
- Stage 1 (transition minimisation), registered:
  - N1d = popcount(data).
  - If N1d > 4, or (N1d == 4 and data[0] == 0): use xnor, qm[8] = 0. Otherwise use xor, qm[8] = 1.
  - qm[0] = data[0]; qm[i] = qm[i-1] op data[i] for i = 1..7.
  - mode, sync and ctrl are carried alongside in the same register.
- Stage 2 (DC balance), video mode. N1/N0 are the counts of ones/zeros in qm[7:0]; cnt is the current disparity.
  - Case A, cnt == 0 or N1 == N0:
    - out = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]}
    - cnt += qm[8] ? (N1 - N0) : (N0 - N1)
  - Case B, (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1):
    - out = {1, qm[8], ~qm[7:0]}
    - cnt += 2*qm[8] + (N0 - N1)
  - Case C, otherwise:
    - out = {0, qm[8], qm[7:0]}
    - cnt += (N1 - N0) - 2*(~qm[8])
- Disparity arithmetic:
  - Signed 5-bit, two's complement. The value stays within -10..+10 and must never wrap.
  - Compute intermediates in 6 bits.
- Non-video modes: cnt is forced to 0 on the same edge the word is output.
- Control words (by sync): 00 -> 0x354, 01 -> 0x0AB, 10 -> 0x154, 11 -> 0x2AB.
- TERC4 words (by ctrl, 0..F):
  - 0x29C, 0x263, 0x2E4, 0x2E2, 0x171, 0x11E, 0x18E, 0x13C
  - 0x2CC, 0x139, 0x19C, 0x2C6, 0x28E, 0x271, 0x163, 0x2C3
- Video guard: CHANNEL 0 and 2 -> 0x2CC; CHANNEL 1 -> 0x133.
- Data guard: CHANNEL 1 and 2 -> 0x133; CHANNEL 0 -> TERC4(ctrl). The caller drives ctrl = {1, 1, vsync, hsync}.
- Mode changes take effect per word; there is no settling state.
  - Video resuming after any non-video word always starts from cnt = 0.

Decomposition:
- Shared package tmds_pkg holds:
  - mode enumeration (MODE_CTRL, MODE_VIDEO, MODE_TERC4, MODE_VGUARD, MODE_DGUARD)
  - CTRL_00..CTRL_11 constants
  - TERC4 16-entry table
  - GUARD_VIDEO_02 / GUARD_VIDEO_1 / GUARD_DATA constants
  - The decoder shares these constants.
- One sub-module, tmds_qm_stage: stage-1 popcount, xor/xnor chain and registered qm[8:0] plus its N1/N0 counts. Stage 2 stays in the top module.

Test Plan:
- Reset held 5 cycles, then mode = 0, sync = 2'b11: out = 0x354 during reset and for the first 2 cycles, then 0x2AB from cycle 3; disparity = 0 throughout.
- From disparity 0, mode = 1 with data = 0x00 for 4 cycles: out = 0x100, 0x3FF, 0x100, 0x3FF and disparity = -8, 2, -6, 4.
- Disparity clear on mode change: video 0x00 for 3 words, then one control word, then video 0x00: the first resumed word = 0x100 with disparity -8.
- mode = 2 with ctrl = 4'h5 -> 0x11E. mode = 3 -> 0x2CC on CHANNEL 0 and 0x133 on CHANNEL 1. mode = 4 on CHANNEL 0 with ctrl = 4'hE -> 0x163. mode = 7 with sync = 01 -> 0x0AB.
- Async reset pulse mid-video, between clock edges: out = 0x354 and disparity = 0 before the next edge. Normal encoding resumes 2 cycles after release.
- Loopback with 100k random video bytes and random mode interleaving through tmds_8b10b_decoder:
  - Video words give data_valid = 1 and recover the byte exactly.
  - Control words give sync_valid with a matching sync value; TERC4 words give ctrl_valid with a matching nibble.
  - |disparity| ≤ 10 at all times.
